// File: rtl/locus_pkg.sv
// Shared types and constants for the colour locus finder: RGB333 field layout,
// channel indices, FSM encoding and the per-channel pixel cost function.
package locus_pkg;

  localparam int PIX_W   = 9;
  localparam int FIELD_W = 3;
  localparam int R_LSB   = 6;
  localparam int G_LSB   = 3;
  localparam int B_LSB   = 0;
  localparam int COST_W  = 4;

  localparam int CH_R = 0;
  localparam int CH_G = 1;
  localparam int CH_B = 2;
  localparam int NCH  = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_COMPARE,
    ST_DONE
  } state_t;

  // max(0, 2*c - o1 - o2); the 6-bit signed range covers -14..14.
  function automatic logic [COST_W-1:0] chan_cost(input logic [FIELD_W-1:0] c,
                                                  input logic [FIELD_W-1:0] o1,
                                                  input logic [FIELD_W-1:0] o2);
    logic signed [5:0] d;
    d = $signed({2'b00, c, 1'b0}) - $signed({3'b000, o1}) - $signed({3'b000, o2});
    return d[5] ? '0 : d[COST_W-1:0];
  endfunction

endpackage

// File: rtl/color_locus_finder_if.sv
// Frame buffer read port: address/request out of the finder, pixel data back in.
interface color_locus_finder_if;
  logic       mem_request;
  logic [8:0] mem_hcount;
  logic [8:0] mem_vcount;
  logic [8:0] mem_pixel_data;

  modport master (
    output mem_request,
    output mem_hcount,
    output mem_vcount,
    input  mem_pixel_data
  );

  modport slave (
    input  mem_request,
    input  mem_hcount,
    input  mem_vcount,
    output mem_pixel_data
  );
endinterface

// File: rtl/rgb333_cost.sv
// Combinational per-channel cost for one RGB333 pixel.
module rgb333_cost
  import locus_pkg::*;
(
  input  logic [PIX_W-1:0]  i_pixel,
  output logic [COST_W-1:0] o_cost_r,
  output logic [COST_W-1:0] o_cost_g,
  output logic [COST_W-1:0] o_cost_b
);

  logic [FIELD_W-1:0] w_r;
  logic [FIELD_W-1:0] w_g;
  logic [FIELD_W-1:0] w_b;

  assign w_r = i_pixel[R_LSB +: FIELD_W];
  assign w_g = i_pixel[G_LSB +: FIELD_W];
  assign w_b = i_pixel[B_LSB +: FIELD_W];

  assign o_cost_r = chan_cost(w_r, w_g, w_b);
  assign o_cost_g = chan_cost(w_g, w_r, w_b);
  assign o_cost_b = chan_cost(w_b, w_r, w_g);

endmodule

// File: rtl/color_locus_finder.sv
// Block-raster scan of a frame buffer reporting, per colour channel, the centre of
// the highest-scoring block. Optional score outputs under COLOR_LOCUS_SCORE_OUT_EN.
//
// state      | meaning
// IDLE       | waiting for start; results held
// FETCH      | issuing BLK*BLK pixel reads for current block
// DRAIN      | MEM_LATENCY cycles for in-flight data to land
// COMPARE    | update per-channel bests, advance block index
// DONE       | one-cycle done pulse; results loaded on entry
module color_locus_finder
  import locus_pkg::*;
#(
  parameter int FRAME_W     = 240,
  parameter int FRAME_H     = 240,
  parameter int BLK_LOG2    = 2,
  parameter int MEM_LATENCY = 2,
  localparam int ACC_W      = 4 + 2 * BLK_LOG2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_start,
  input  logic [ACC_W-1:0]     i_min_score,
  color_locus_finder_if.master mem,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [8:0]           o_red_x,
  output logic [8:0]           o_red_y,
  output logic [8:0]           o_green_x,
  output logic [8:0]           o_green_y,
  output logic [8:0]           o_blue_x,
  output logic [8:0]           o_blue_y,
  output logic                 o_red_found,
  output logic                 o_green_found,
  output logic                 o_blue_found
`ifdef COLOR_LOCUS_SCORE_OUT_EN
  ,
  output logic [ACC_W-1:0]     o_red_score,
  output logic [ACC_W-1:0]     o_green_score,
  output logic [ACC_W-1:0]     o_blue_score
`endif
);

  localparam int BLK   = 1 << BLK_LOG2;
  localparam int NBX   = FRAME_W >> BLK_LOG2;
  localparam int NBY   = FRAME_H >> BLK_LOG2;
  localparam int TMR_W = 16;

  localparam logic [TMR_W-1:0] PIX_LAST = TMR_W'(BLK * BLK - 1);
  localparam logic [TMR_W-1:0] LAT_LAST = TMR_W'(MEM_LATENCY - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
  localparam logic [TMR_W-1:0] TMR_MASK = TMR_W'(BLK - 1);
  localparam logic [8:0]       BX_LAST  = 9'(NBX - 1);
  localparam logic [8:0]       BY_LAST  = 9'(NBY - 1);
  localparam logic [8:0]       HALF     = 9'(BLK / 2);

  state_t                 r_state;
  logic [TMR_W-1:0]       r_tmr;
  logic [8:0]             r_bx;
  logic [8:0]             r_by;
  logic                   r_req;
  logic [8:0]             r_hc;
  logic [8:0]             r_vc;
  logic                   r_busy;
  logic                   r_done;
  logic [MEM_LATENCY-1:0] r_vld;

  logic [ACC_W-1:0] r_acc     [NCH];
  logic [ACC_W-1:0] r_best    [NCH];
  logic [8:0]       r_best_bx [NCH];
  logic [8:0]       r_best_by [NCH];
  logic [8:0]       r_x       [NCH];
  logic [8:0]       r_y       [NCH];
  logic             r_found   [NCH];
`ifdef COLOR_LOCUS_SCORE_OUT_EN
  logic [ACC_W-1:0] r_score   [NCH];
`endif

  logic [COST_W-1:0] w_cost     [NCH];
  logic [ACC_W-1:0]  w_best_nxt [NCH];
  logic [8:0]        w_bbx_nxt  [NCH];
  logic [8:0]        w_bby_nxt  [NCH];
  logic [TMR_W-1:0]  w_pix_nxt;
  logic [8:0]        w_i;
  logic [8:0]        w_j;
  logic [8:0]        w_bx_nxt;
  logic [8:0]        w_by_nxt;
  logic              w_blk_last;
  logic              w_tag;

  rgb333_cost u_cost (
    .i_pixel  (mem.mem_pixel_data),
    .o_cost_r (w_cost[CH_R]),
    .o_cost_g (w_cost[CH_G]),
    .o_cost_b (w_cost[CH_B])
  );

  // Address of the pixel following the one currently on the bus.
  assign w_pix_nxt = PIX_LAST - r_tmr + TMR_ONE;
  assign w_i       = 9'(w_pix_nxt & TMR_MASK);
  assign w_j       = 9'((w_pix_nxt >> BLK_LOG2) & TMR_MASK);

  assign w_blk_last = (r_bx == BX_LAST) && (r_by == BY_LAST);
  assign w_bx_nxt   = (r_bx == BX_LAST) ? 9'd0 : r_bx + 9'd1;
  assign w_by_nxt   = (r_bx == BX_LAST) ? r_by + 9'd1 : r_by;
  assign w_tag      = r_vld[MEM_LATENCY-1];

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      w_best_nxt[c] = r_best[c];
      w_bbx_nxt[c]  = r_best_bx[c];
      w_bby_nxt[c]  = r_best_by[c];
      if (r_acc[c] > r_best[c]) begin
        w_best_nxt[c] = r_acc[c];
        w_bbx_nxt[c]  = r_bx;
        w_bby_nxt[c]  = r_by;
      end
    end
  end

  // Returning data is tagged by a delayed copy of the request.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld <= '0;
      for (int c = 0; c < NCH; c++) r_acc[c] <= '0;
    end else begin
      r_vld <= (r_vld << 1) | MEM_LATENCY'(r_req);
      for (int c = 0; c < NCH; c++) begin
        if (r_state == ST_COMPARE) r_acc[c] <= '0;
        else if (w_tag)            r_acc[c] <= r_acc[c] + ACC_W'(w_cost[c]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_tmr   <= '0;
      r_bx    <= '0;
      r_by    <= '0;
      r_req   <= 1'b0;
      r_hc    <= '0;
      r_vc    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        r_best[c]    <= '0;
        r_best_bx[c] <= '0;
        r_best_by[c] <= '0;
        r_x[c]       <= '0;
        r_y[c]       <= '0;
        r_found[c]   <= 1'b0;
`ifdef COLOR_LOCUS_SCORE_OUT_EN
        r_score[c]   <= '0;
`endif
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state <= ST_FETCH;
            r_busy  <= 1'b1;
            r_req   <= 1'b1;
            r_tmr   <= PIX_LAST;
            r_bx    <= '0;
            r_by    <= '0;
            r_hc    <= '0;
            r_vc    <= '0;
            for (int c = 0; c < NCH; c++) begin
              r_best[c]    <= '0;
              r_best_bx[c] <= '0;
              r_best_by[c] <= '0;
            end
          end
        end
        ST_FETCH: begin
          if (r_tmr == '0) begin
            r_state <= ST_DRAIN;
            r_req   <= 1'b0;
            r_tmr   <= LAT_LAST;
          end else begin
            r_tmr <= r_tmr - TMR_ONE;
            r_hc  <= (r_bx << BLK_LOG2) + w_i;
            r_vc  <= (r_by << BLK_LOG2) + w_j;
          end
        end
        ST_DRAIN: begin
          if (r_tmr == '0) r_state <= ST_COMPARE;
          else             r_tmr   <= r_tmr - TMR_ONE;
        end
        ST_COMPARE: begin
          for (int c = 0; c < NCH; c++) begin
            r_best[c]    <= w_best_nxt[c];
            r_best_bx[c] <= w_bbx_nxt[c];
            r_best_by[c] <= w_bby_nxt[c];
          end
          if (w_blk_last) begin
            // Results come from the post-compare bests so the last block counts.
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
              r_x[c]     <= (w_bbx_nxt[c] << BLK_LOG2) + HALF;
              r_y[c]     <= (w_bby_nxt[c] << BLK_LOG2) + HALF;
              r_found[c] <= (w_best_nxt[c] >= i_min_score);
`ifdef COLOR_LOCUS_SCORE_OUT_EN
              r_score[c] <= w_best_nxt[c];
`endif
            end
          end else begin
            r_state <= ST_FETCH;
            r_req   <= 1'b1;
            r_tmr   <= PIX_LAST;
            r_bx    <= w_bx_nxt;
            r_by    <= w_by_nxt;
            r_hc    <= w_bx_nxt << BLK_LOG2;
            r_vc    <= w_by_nxt << BLK_LOG2;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem.mem_request = r_req;
  assign mem.mem_hcount  = r_hc;
  assign mem.mem_vcount  = r_vc;

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_red_x       = r_x[CH_R];
  assign o_red_y       = r_y[CH_R];
  assign o_green_x     = r_x[CH_G];
  assign o_green_y     = r_y[CH_G];
  assign o_blue_x      = r_x[CH_B];
  assign o_blue_y      = r_y[CH_B];
  assign o_red_found   = r_found[CH_R];
  assign o_green_found = r_found[CH_G];
  assign o_blue_found  = r_found[CH_B];
`ifdef COLOR_LOCUS_SCORE_OUT_EN
  assign o_red_score   = r_score[CH_R];
  assign o_green_score = r_score[CH_G];
  assign o_blue_score  = r_score[CH_B];
`endif

endmodule

// File: tb/tb_color_locus_finder.sv
// Directed bench for color_locus_finder on a 16x16 frame with 4x4 blocks.
module tb_color_locus_finder;

  localparam int FW = 16;
  localparam int FH = 16;
  localparam int BL = 2;
  localparam int ML = 2;
  localparam int AW = 4 + 2 * BL;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_start;
  logic [AW-1:0] i_min_score;
  logic          o_busy, o_done;
  logic [8:0]    o_red_x, o_red_y, o_green_x, o_green_y, o_blue_x, o_blue_y;
  logic          o_red_found, o_green_found, o_blue_found;
`ifdef COLOR_LOCUS_SCORE_OUT_EN
  logic [AW-1:0] o_red_score, o_green_score, o_blue_score;
`endif

  color_locus_finder_if mem_if ();

  color_locus_finder #(
    .FRAME_W     (FW),
    .FRAME_H     (FH),
    .BLK_LOG2    (BL),
    .MEM_LATENCY (ML)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_start       (i_start),
    .i_min_score   (i_min_score),
    .mem           (mem_if.master),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_red_x       (o_red_x),
    .o_red_y       (o_red_y),
    .o_green_x     (o_green_x),
    .o_green_y     (o_green_y),
    .o_blue_x      (o_blue_x),
    .o_blue_y      (o_blue_y),
    .o_red_found   (o_red_found),
    .o_green_found (o_green_found),
    .o_blue_found  (o_blue_found)
`ifdef COLOR_LOCUS_SCORE_OUT_EN
    ,
    .o_red_score   (o_red_score),
    .o_green_score (o_green_score),
    .o_blue_score  (o_blue_score)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame buffer model: data for the address seen in cycle k is presented in
  // cycle k+ML; untagged cycles carry strong red to expose mistagging.
  logic [8:0] frame [256];
  logic [8:0] hist [ML+1];
  always @(negedge clk) begin
    for (int k = ML; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = {mem_if.mem_request, mem_if.mem_vcount[3:0], mem_if.mem_hcount[3:0]};
    mem_if.mem_pixel_data = hist[ML][8] ? frame[hist[ML][7:0]] : 9'h1C0;
  end

  logic cnt_clr = 1'b0;
  int   n_done = 0;
  int   n_req  = 0;
  always @(posedge clk) begin
    #1;
    if (cnt_clr) begin
      n_done = 0;
      n_req  = 0;
    end else begin
      if (o_done) n_done++;
      if (mem_if.mem_request) n_req++;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_frame();
    for (int i = 0; i < 256; i++) frame[i] = 9'h000;
  endtask

  task automatic fill_block(input int bx, input int by, input logic [8:0] v);
    for (int j = 0; j < 4; j++)
      for (int i = 0; i < 4; i++)
        frame[(by * 4 + j) * 16 + bx * 4 + i] = v;
  endtask

  task automatic check_ch(input string nm, input logic [8:0] x, input logic [8:0] y,
                          input logic f, input int ex, input int ey, input int ef);
    check_val({nm, "_x"}, 32'(x), 32'(ex));
    check_val({nm, "_y"}, 32'(y), 32'(ey));
    check_val({nm, "_found"}, 32'(f), 32'(ef));
  endtask

  int t0;

  task automatic run_scan(input int min, input bit extra, output int done_at);
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr     = 1'b0;
    i_min_score = AW'(min);
    i_start     = 1'b1;
    t0          = cyc;
    @(negedge clk);
    i_start = 1'b0;
    done_at = -1;
    while (cyc - t0 < 400) begin
      i_start = extra && ((cyc - t0 == 50) || (cyc - t0 == 120) || (cyc - t0 == 304));
      if (o_done) begin
        done_at = cyc - t0;
        break;
      end
      @(negedge clk);
    end
    i_start = 1'b0;
  endtask

  int d;

  initial begin
    reset = 1'b1;
    i_start = 1'b0;
    i_min_score = AW'(100);
    for (int k = 0; k <= ML; k++) hist[k] = '0;
    clear_frame();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_val("rst_busy", 32'(o_busy), 0);
    check_val("rst_done", 32'(o_done), 0);
    check_val("rst_req", 32'(mem_if.mem_request), 0);
    check_ch("rst_red", o_red_x, o_red_y, o_red_found, 0, 0, 0);

    // Blank frame with stray start pulses during the scan.
    run_scan(100, 1'b1, d);
    check_val("blank_done_cycle", 32'(d), 305);
    check_ch("blank_red", o_red_x, o_red_y, o_red_found, 2, 2, 0);
    check_ch("blank_green", o_green_x, o_green_y, o_green_found, 2, 2, 0);
    check_ch("blank_blue", o_blue_x, o_blue_y, o_blue_found, 2, 2, 0);
    repeat (5) @(negedge clk);
    check_val("blank_busy_after", 32'(o_busy), 0);
    check_val("blank_done_pulses", 32'(n_done), 1);
    check_val("blank_req_cycles", 32'(n_req), 256);

    // Red block (2,1).
    clear_frame();
    fill_block(2, 1, 9'h1C0);
    run_scan(100, 1'b0, d);
    check_val("red_done_cycle", 32'(d), 305);
    check_ch("red_red", o_red_x, o_red_y, o_red_found, 10, 6, 1);
    check_ch("red_green", o_green_x, o_green_y, o_green_found, 2, 2, 0);
    check_ch("red_blue", o_blue_x, o_blue_y, o_blue_found, 2, 2, 0);
`ifdef COLOR_LOCUS_SCORE_OUT_EN
    check_val("red_score", 32'(o_red_score), 224);
    check_val("red_green_score", 32'(o_green_score), 0);
`endif

    // Tie: first block in raster order wins.
    clear_frame();
    fill_block(1, 0, 9'h1C0);
    fill_block(3, 3, 9'h1C0);
    run_scan(100, 1'b0, d);
    check_ch("tie_red", o_red_x, o_red_y, o_red_found, 6, 2, 1);

    // Green block (0,3) against threshold boundary.
    clear_frame();
    fill_block(0, 3, 9'h038);
    run_scan(225, 1'b0, d);
    check_ch("green225", o_green_x, o_green_y, o_green_found, 2, 14, 0);
    check_ch("green225_red", o_red_x, o_red_y, o_red_found, 2, 2, 0);
    run_scan(224, 1'b0, d);
    check_ch("green224", o_green_x, o_green_y, o_green_found, 2, 14, 1);

    // Mid-scan reset, then a fresh scan on a blue frame.
    @(negedge clk);
    i_min_score = AW'(100);
    i_start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    i_start = 1'b0;
    while (cyc - t0 < 150) @(negedge clk);
    check_val("mid_busy", 32'(o_busy), 1);
    check_val("mid_hold_green_y", 32'(o_green_y), 14);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_val("mrst_busy", 32'(o_busy), 0);
    check_val("mrst_req", 32'(mem_if.mem_request), 0);
    check_ch("mrst_green", o_green_x, o_green_y, o_green_found, 0, 0, 0);
    check_ch("mrst_red", o_red_x, o_red_y, o_red_found, 0, 0, 0);
    repeat (3) @(negedge clk);
    check_val("mrst_idle_busy", 32'(o_busy), 0);
    clear_frame();
    fill_block(3, 2, 9'h007);
    run_scan(100, 1'b0, d);
    check_val("blue_done_cycle", 32'(d), 305);
    check_ch("blue_blue", o_blue_x, o_blue_y, o_blue_found, 14, 10, 1);
    check_ch("blue_red", o_red_x, o_red_y, o_red_found, 2, 2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
